// File: rtl/mcycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle multiply/divide controller:
// operation encodings, FSM state encoding and the default datapath width.
package mcycle_ctrl_pkg;

   localparam int unsigned WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      OP_SMUL = 2'b00,
      OP_UMUL = 2'b01,
      OP_SDIV = 2'b10,
      OP_UDIV = 2'b11
   } mcycle_op_e;

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_COMPUTING = 1'b1
   } state_e;

   function automatic logic op_is_div(input mcycle_op_e op);
      return op inside {OP_SDIV, OP_UDIV};
   endfunction

   function automatic logic op_is_signed(input mcycle_op_e op);
      return op inside {OP_SMUL, OP_SDIV};
   endfunction

endpackage

// File: rtl/mcycle_step.sv
// One iteration of the shared shift-add (multiply) / restoring
// shift-subtract (divide) datapath acting on the {hi, lo} working pair.
module mcycle_step
   import mcycle_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  mcycle_op_e       op,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   assign sum     = {1'b0, hi} + {1'b0, opnd};
   assign shifted = {hi, lo[WIDTH-1]};
   assign borrow  = shifted < {1'b0, opnd};
   // The partial remainder always stays below the divisor, so the low WIDTH bits of the difference suffice.
   assign diff    = shifted[WIDTH-1:0] - opnd;

   always_comb begin
      hi_next = hi;
      lo_next = lo;
      if (op_is_div(op)) begin
         hi_next = borrow ? shifted[WIDTH-1:0] : diff;
         lo_next = {lo[WIDTH-2:0], ~borrow};
      end else if (lo[0]) begin
         {hi_next, lo_next} = {sum, lo[WIDTH-1:1]};
      end else begin
         {hi_next, lo_next} = {1'b0, hi, lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle multiply/divide controller: captures operands on Start, runs
// WIDTH iterations on absolute values, then applies signs and registers results.
module mcycle_ctrl
   import mcycle_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned    CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_e           state, state_next;
   logic             capture, last;
   logic [CW-1:0]    count;
   mcycle_op_e       op_in, op_q;
   logic [WIDTH-1:0] hi, lo, opnd, op1_q;
   logic [WIDTH-1:0] hi_next, lo_next;
   logic             neg_a, neg_b, div_zero;
   logic             sign1, sign2;
   logic [WIDTH-1:0] abs1, abs2, res1, res2;
   logic [2*WIDTH-1:0] prod;

   assign op_in = mcycle_op_e'(MCycleOp);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      last       = 1'b0;
      Busy       = 1'b0;
      case (state)
         S_IDLE: begin
            Busy = Start;
            if (Start) begin
               capture    = 1'b1;
               state_next = S_COMPUTING;
            end
         end
         S_COMPUTING: begin
            Busy = 1'b1;
            if (count == LAST) begin
               last       = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      sign1 = op_is_signed(op_in) & Operand1[WIDTH-1];
      sign2 = op_is_signed(op_in) & Operand2[WIDTH-1];
      abs1  = sign1 ? -Operand1 : Operand1;
      abs2  = sign2 ? -Operand2 : Operand2;
   end

   mcycle_step #(.WIDTH(WIDTH)) u_step (
      .op      (op_q),
      .hi      (hi),
      .lo      (lo),
      .opnd    (opnd),
      .hi_next (hi_next),
      .lo_next (lo_next)
   );

   // Final results are formed from the last step's outputs so they register on the same edge.
   always_comb begin
      prod = {hi_next, lo_next};
      res1 = lo_next;
      res2 = hi_next;
      if (!op_is_div(op_q)) begin
         {res2, res1} = neg_a ? -prod : prod;
      end else if (div_zero) begin
         res1 = '1;
         res2 = op1_q;
      end else begin
         res1 = neg_a ? -lo_next : lo_next;
         res2 = neg_b ? -hi_next : hi_next;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         op_q     <= OP_SMUL;
         count    <= '0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         op1_q    <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
         Result1  <= '0;
         Result2  <= '0;
         Done     <= 1'b0;
      end else begin
         Done <= last;
         if (capture) begin
            op_q     <= op_in;
            count    <= '0;
            op1_q    <= Operand1;
            neg_a    <= sign1 ^ sign2;
            neg_b    <= sign1;
            div_zero <= op_is_div(op_in) && (Operand2 == '0);
            hi       <= '0;
            lo       <= op_is_div(op_in) ? abs1 : abs2;
            opnd     <= op_is_div(op_in) ? abs2 : abs1;
         end else if (state == S_COMPUTING) begin
            hi    <= hi_next;
            lo    <= lo_next;
            count <= count + 1'b1;
         end
         if (last) begin
            Result1 <= res1;
            Result2 <= res2;
         end
      end
   end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed self-checking bench for mcycle_ctrl: arithmetic corner cases,
// latency, result holding, mid-operation reset and back-to-back starts.
module tb_mcycle_ctrl;

   localparam logic [1:0] SMUL = 2'b00;
   localparam logic [1:0] UMUL = 2'b01;
   localparam logic [1:0] SDIV = 2'b10;
   localparam logic [1:0] UDIV = 2'b11;

   logic        CLK;
   logic        RESET;
   logic        Start;
   logic [1:0]  MCycleOp;
   logic [31:0] Operand1, Operand2;
   logic [31:0] Result1, Result2;
   logic        Busy, Done;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] prev1, prev2;

   mcycle_ctrl #(.WIDTH(32)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .Start    (Start),
      .MCycleOp (MCycleOp),
      .Operand1 (Operand1),
      .Operand2 (Operand2),
      .Result1  (Result1),
      .Result2  (Result2),
      .Busy     (Busy),
      .Done     (Done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      Start    = 1'b1;
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
   endtask

   // Call right after start_op on a falling edge; follows the operation to its Done cycle.
   task automatic finish_op(input string tag, input logic [31:0] e1, input logic [31:0] e2);
      int busy_cnt;
      bit seen;
      busy_cnt = 1;
      seen     = 1'b0;
      #1 check({tag, " busy_in_start_cycle"}, 64'(Busy), 64'd1);
      @(posedge CLK);
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         Start    = 1'b0;
         Operand1 = ~Operand1;
         Operand2 = Operand2 ^ 32'h5A5A_0F0F;
         if (Done) begin
            seen = 1'b1;
            break;
         end
         if (Busy) busy_cnt++;
         check({tag, " hold_r1"}, 64'(Result1), 64'(prev1));
         check({tag, " hold_r2"}, 64'(Result2), 64'(prev2));
      end
      check({tag, " done_seen"}, 64'(seen), 64'd1);
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
      #1;
      check({tag, " busy_after"}, 64'(Busy), 64'd0);
      check({tag, " r1"}, 64'(Result1), 64'(e1));
      check({tag, " r2"}, 64'(Result2), 64'(e2));
      @(negedge CLK);
      check({tag, " done_one_cycle"}, 64'(Done), 64'd0);
      check({tag, " r1_held"}, 64'(Result1), 64'(e1));
      check({tag, " r2_held"}, 64'(Result2), 64'(e2));
      prev1 = e1;
      prev2 = e2;
   endtask

   initial begin
      RESET    = 1'b1;
      Start    = 1'b0;
      MCycleOp = 2'b00;
      Operand1 = '0;
      Operand2 = '0;
      prev1    = '0;
      prev2    = '0;
      repeat (2) @(negedge CLK);
      check("reset busy", 64'(Busy), 64'd0);
      check("reset done", 64'(Done), 64'd0);
      check("reset r1", 64'(Result1), 64'd0);
      check("reset r2", 64'(Result2), 64'd0);

      // Start presented in the same cycle reset releases.
      RESET = 1'b0;
      start_op(UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish_op("umul_max", 32'h0000_0001, 32'hFFFF_FFFE);

      @(negedge CLK); start_op(SMUL, 32'hFFFF_FFFD, 32'd7);
      finish_op("smul_m3x7", 32'hFFFF_FFEB, 32'hFFFF_FFFF);

      @(negedge CLK); start_op(SMUL, 32'h8000_0000, 32'h8000_0000);
      finish_op("smul_minxmin", 32'h0000_0000, 32'h4000_0000);

      @(negedge CLK); start_op(SDIV, 32'hFFFF_FFF9, 32'd2);
      finish_op("sdiv_m7d2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

      @(negedge CLK); start_op(SDIV, 32'd7, 32'hFFFF_FFFE);
      finish_op("sdiv_7dm2", 32'hFFFF_FFFD, 32'h0000_0001);

      @(negedge CLK); start_op(UDIV, 32'd100, 32'd7);
      finish_op("udiv_100d7", 32'd14, 32'd2);

      @(negedge CLK); start_op(UDIV, 32'd5, 32'd0);
      finish_op("udiv_5d0", 32'hFFFF_FFFF, 32'd5);

      @(negedge CLK); start_op(SDIV, 32'hFFFF_FFF9, 32'd0);
      finish_op("sdiv_m7d0", 32'hFFFF_FFFF, 32'hFFFF_FFF9);

      @(negedge CLK); start_op(SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op("sdiv_min_dm1", 32'h8000_0000, 32'd0);

      @(negedge CLK); start_op(UDIV, 32'd77, 32'd10);
      finish_op("udiv_77d10", 32'd7, 32'd7);

      // Reset in the middle of an operation, away from any clock edge.
      @(negedge CLK); start_op(UMUL, 32'd6, 32'd5);
      @(posedge CLK);
      repeat (10) @(negedge CLK);
      Start = 1'b0;
      #2 RESET = 1'b1;
      #1;
      check("midreset busy", 64'(Busy), 64'd0);
      check("midreset done", 64'(Done), 64'd0);
      check("midreset r1", 64'(Result1), 64'd0);
      check("midreset r2", 64'(Result2), 64'd0);
      prev1 = '0;
      prev2 = '0;
      @(negedge CLK);
      RESET = 1'b0;
      start_op(SMUL, 32'd6, 32'd7);
      finish_op("mul_6x7_after_reset", 32'd42, 32'd0);

      // Start held high: second operation captured in the Done cycle.
      @(negedge CLK); start_op(UMUL, 32'd3, 32'd4);
      #1 check("b2b busy_start", 64'(Busy), 64'd1);
      @(posedge CLK);
      for (int k = 1; k <= 66; k++) begin
         @(negedge CLK);
         if (k == 5)  begin MCycleOp = UDIV; Operand1 = 32'd9;     Operand2 = 32'd0;     end
         if (k == 32) begin MCycleOp = UDIV; Operand1 = 32'd100;   Operand2 = 32'd7;     end
         if (k == 40) begin MCycleOp = SMUL; Operand1 = 32'hDEAD;  Operand2 = 32'h1234;  end
         if (k == 65) Start = 1'b0;
         if (k == 33) begin
            check("b2b first_done", 64'(Done), 64'd1);
            check("b2b busy_in_done", 64'(Busy), 64'd1);
            check("b2b first_r1", 64'(Result1), 64'd12);
            check("b2b first_r2", 64'(Result2), 64'd0);
         end else if (k == 66) begin
            check("b2b second_done", 64'(Done), 64'd1);
            #1;
            check("b2b busy_end", 64'(Busy), 64'd0);
            check("b2b second_r1", 64'(Result1), 64'd14);
            check("b2b second_r2", 64'(Result2), 64'd2);
         end else begin
            check("b2b busy", 64'(Busy), 64'd1);
            check("b2b no_done", 64'(Done), 64'd0);
            if (k > 33) check("b2b hold_r1", 64'(Result1), 64'd12);
         end
      end
      @(negedge CLK);
      check("b2b done_one_cycle", 64'(Done), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
